snake_dir_ctrl: RTL
===================

Name: snake_dir_ctrl

Overview:
- Consumes the slow square wave from the game clock divider (rising edge every 10000 `clk` cycles) and turns it into single-cycle tick enables.
- Debounces the four direction buttons and the centre (pause) button on those ticks.
- Holds the snake heading with reversal protection and emits a one-cycle `move_stb` every MOVE_TICKS ticks for the snake body/board logic downstream.
- Everything runs on `clk`; `div_clk_in` is data, never a clock.

Parameters:
- DEB_TICKS, 4: consecutive ticks a button level must be stable before it is accepted.
- MOVE_TICKS, 8: ticks between consecutive `move_stb` pulses while running.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- div_clk_in  in  1  divided square wave from the clock divider, synchronous to `clk`
- btn_up  in  1  raw button, active-high
- btn_down  in  1  raw button, active-high
- btn_left  in  1  raw button, active-high
- btn_right  in  1  raw button, active-high
- btn_c  in  1  raw pause button, active-high
- dir  out  2  applied heading: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT
- move_stb  out  1  one-cycle step strobe
- running  out  1  high in RUN state
- tick  out  1  one-cycle pulse on each rising edge of `div_clk_in`

Behaviour:
- Interface:
  - One clock, `clk`.
  - Reset `reset` is synchronous and active-high.
  - All outputs are registered.
- Reset values:
  - `dir` = RIGHT, `move_stb` = 0, `running` = 0, `tick` = 0.
  - FSM = IDLE, pending register empty, all debounce counters and the move counter = 0.
  - Previous-sample register of `div_clk_in` = 0.
- Tick:
  - `tick` = `div_clk_in` AND NOT previous sample, registered.
  - No synchroniser is needed; `div_clk_in` is synchronous to `clk`.
  - Latency: `tick` is high 1 cycle after the `div_clk_in` rise and lasts exactly 1 `clk` cycle.
- Debounce, per button:
  - Sampled only on `tick`.
  - Sample == accepted level: counter clears.
  - Sample differs: counter increments. When it reaches DEB_TICKS-1 on a tick, the accepted level flips and the counter clears.
  - A press event is the accepted level going 0→1; it is a one-cycle internal pulse.
  - Counter width is $clog2(DEB_TICKS)+1.
- Direction request:
  - On a press event, the requested heading is chosen by priority UP > DOWN > LEFT > RIGHT if several fire in the same cycle.
  - A request that is the opposite of applied `dir`, or equal to it, is discarded.
  - An accepted request is written to the pending register; last write wins.
  - Pending is applied to `dir` only in the cycle `move_stb` fires, then pending clears. This prevents two quick turns from producing a 180° reversal.
- FSM states and transitions:
  - IDLE → RUN on any direction press event. Reversal check is skipped here, so `dir` takes the pressed heading immediately.
  - RUN → PAUSE on a `btn_c` press event.
  - PAUSE → RUN on a `btn_c` press event.
  - `btn_c` in IDLE is ignored.
  - In PAUSE, direction presses are discarded, the move counter freezes and pending is kept.
- Move counter, active in RUN only:
  - Increments on each `tick`.
  - On the tick where it equals MOVE_TICKS-1, it wraps to 0 and `move_stb` = 1 on the next cycle for one cycle.
  - Entering RUN from IDLE clears the counter, so the first `move_stb` comes MOVE_TICKS ticks later.
- Simultaneous events: a `btn_c` press and the terminal move tick in the same cycle → the strobe still fires, then the FSM enters PAUSE.
- Reset mid-operation returns everything to the reset values on the next edge.

Optional Feature:
- Macro: `SNAKE_DIR_QUEUE_EN`.
- Defined:
  - Pending is replaced by a 2-entry FIFO.
  - The reversal/equality check for a new request is made against the last queued entry, or against `dir` if the queue is empty.
  - Requests arriving while the queue is full are dropped.
  - Each `move_stb` pops one entry.
- Undefined: single pending register as described above.

Decomposition:
- Shared package `snake_pkg`:
  - `dir_t` (2-bit enum UP/DOWN/LEFT/RIGHT).
  - `opposite()` function.
  - FSM state enum IDLE/RUN/PAUSE.
- Sub-module `btn_debounce`:
  - Ports: clk, reset, tick, raw, level, press.
  - Instantiated 5 times.

Test Plan (bench params DEB_TICKS=3, MOVE_TICKS=4; `div_clk_in` driven with period 8 `clk`):
- Reset, then `div_clk_in` toggling for 40 cycles → `tick` is 1-cycle pulses 8 cycles apart, `dir`=11, `running`=0, no `move_stb`.
- Hold `btn_up` high for 3 ticks from IDLE → `running`=1, `dir`=00; first `move_stb` 4 ticks later, then every 4 ticks (32 `clk`).
- `btn_left` glitch lasting 2 ticks → no direction change; the same press held 3 ticks → `dir`=10 at the next `move_stb`, not before.
- Heading UP; press RIGHT then DOWN within one move period → after the strobe `dir`=11; DOWN discarded as a reversal of UP. With the queue macro defined: `dir`=11, then 01 on the following strobe.
- `btn_c` press in RUN → `running`=0 and no `move_stb` for 20 ticks; second press → resume, with the counter continuing from its frozen value.
- Assert `reset` between two strobes → next cycle all outputs at reset values and FSM in IDLE.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared heading/state types for the snake direction controller
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // Opposite headings share the upper bit and differ in the lower one.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - tick-sampled button debouncer with one-cycle press pulse
module btn_debounce #(
  parameter int DEB_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_TICKS) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (tick) begin
        if (raw == level) begin
          cnt <= '0;
        end else if (cnt == CW'(DEB_TICKS - 1)) begin
          level <= raw;
          cnt   <= '0;
          press <= raw;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - snake heading/step controller; SNAKE_DIR_QUEUE_EN selects a 2-deep turn queue
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int DEB_TICKS  = 4,
  parameter int MOVE_TICKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       div_clk_in,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_c,
  output logic [1:0] dir,
  output logic       move_stb,
  output logic       running,
  output logic       tick
);

  localparam int MCW = $clog2(MOVE_TICKS) + 1;

  logic [4:0]     raw_btn;
  logic [4:0]     press;
  logic [4:0]     unused_level;
  logic           div_prev;
  state_t         state;
  dir_t           cur_dir;
  logic [MCW-1:0] mcnt;
  logic           any_dir;
  dir_t           req;
  dir_t           ref_dir;
  logic           req_ok;
  logic           mterm;

  assign raw_btn = {btn_c, btn_right, btn_left, btn_down, btn_up};
  assign dir     = cur_dir;

  for (genvar i = 0; i < 5; i++) begin : g_deb
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .raw   (raw_btn[i]),
      .level (unused_level[i]),
      .press (press[i])
    );
  end

`ifdef SNAKE_DIR_QUEUE_EN
  dir_t       q [2];
  logic [1:0] q_cnt;
  logic       last_idx;
  assign last_idx = (q_cnt == 2'd2);
  assign ref_dir  = (q_cnt == 2'd0) ? cur_dir : q[last_idx];
`else
  dir_t pend;
  logic pend_vld;
  assign ref_dir = cur_dir;
`endif

  always_comb begin
    any_dir = |press[3:0];
    req     = DIR_RIGHT;
    if (press[0])      req = DIR_UP;
    else if (press[1]) req = DIR_DOWN;
    else if (press[2]) req = DIR_LEFT;
    req_ok = any_dir && (req != ref_dir) && (req != opposite(ref_dir));
  end

  assign mterm = (state == ST_RUN) && tick && (mcnt == MCW'(MOVE_TICKS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_prev <= 1'b0;
      tick     <= 1'b0;
      move_stb <= 1'b0;
      running  <= 1'b0;
      state    <= ST_IDLE;
      cur_dir  <= DIR_RIGHT;
      mcnt     <= '0;
`ifdef SNAKE_DIR_QUEUE_EN
      q[0]     <= DIR_RIGHT;
      q[1]     <= DIR_RIGHT;
      q_cnt    <= 2'd0;
`else
      pend     <= DIR_RIGHT;
      pend_vld <= 1'b0;
`endif
    end else begin
      div_prev <= div_clk_in;
      tick     <= div_clk_in & ~div_prev;
      move_stb <= mterm;
      if (state == ST_RUN && tick) mcnt <= mterm ? '0 : mcnt + 1'b1;

      // Turns take effect only on a step so two quick turns cannot fold back.
`ifdef SNAKE_DIR_QUEUE_EN
      if (mterm) begin
        if (q_cnt != 2'd0) begin
          cur_dir <= q[0];
          q[0]    <= q[1];
          q_cnt   <= q_cnt - 1'b1;
        end
      end else if (state == ST_RUN && req_ok && q_cnt != 2'd2) begin
        q[q_cnt[0]] <= req;
        q_cnt       <= q_cnt + 1'b1;
      end
`else
      if (mterm) begin
        if (pend_vld) cur_dir <= pend;
        pend_vld <= 1'b0;
      end else if (state == ST_RUN && req_ok) begin
        pend     <= req;
        pend_vld <= 1'b1;
      end
`endif

      case (state)
        ST_IDLE: if (any_dir) begin
          state   <= ST_RUN;
          running <= 1'b1;
          cur_dir <= req;
          mcnt    <= '0;
        end
        ST_RUN: if (press[4]) begin
          state   <= ST_PAUSE;
          running <= 1'b0;
        end
        ST_PAUSE: if (press[4]) begin
          state   <= ST_RUN;
          running <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
